// File: rtl/div_sequencer.sv
// Multi-cycle radix-2 restoring divider with its sequencing FSM for DIV/DIVU in EX.
// Stalls the pipeline while busy and pulses ready_o with the quotient and remainder.
module div_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             signed_i,
    input  logic             annul_i,
    input  logic [WIDTH-1:0] opa_i,
    input  logic [WIDTH-1:0] opb_i,
    output logic             stall_div,
    output logic             ready_o,
    output logic [WIDTH-1:0] quot_o,
    output logic [WIDTH-1:0] rem_o
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DZERO, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;      // dividend magnitude, shifts into the quotient
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] part_q, part_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic             neg_quot_q, neg_quot_d;
    logic             neg_rem_q, neg_rem_d;
    logic             ready_q, ready_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   trial;
    logic             fits;
    logic [WIDTH-1:0] q_next, r_next;

    always_comb begin
        a_neg = signed_i & opa_i[WIDTH-1];
        b_neg = signed_i & opb_i[WIDTH-1];
        // |MIN| is 2^(WIDTH-1), which the unsigned magnitude holds exactly.
        a_mag = a_neg ? (~opa_i + WIDTH'(1)) : opa_i;
        b_mag = b_neg ? (~opb_i + WIDTH'(1)) : opb_i;

        trial  = {part_q, dvd_q[WIDTH-1]};
        fits   = (trial >= {1'b0, dvs_q});
        q_next = {dvd_q[WIDTH-2:0], fits};
        r_next = fits ? (trial[WIDTH-1:0] - dvs_q) : trial[WIDTH-1:0];

        state_d    = state_q;
        cnt_d      = cnt_q;
        dvd_d      = dvd_q;
        dvs_d      = dvs_q;
        part_d     = part_q;
        opa_d      = opa_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        ready_d    = 1'b0;
        quot_d     = quot_q;
        rem_d      = rem_q;

        unique case (state_q)
            IDLE: begin
                if (start_i && !annul_i) begin
                    opa_d      = opa_i;
                    dvd_d      = a_mag;
                    dvs_d      = b_mag;
                    part_d     = '0;
                    cnt_d      = '0;
                    neg_quot_d = a_neg ^ b_neg;
                    neg_rem_d  = a_neg;
                    state_d    = (opb_i == '0) ? DZERO : BUSY;
                end
            end
            BUSY: begin
                if (annul_i) begin
                    state_d = IDLE;
                end else begin
                    dvd_d  = q_next;
                    part_d = r_next;
                    cnt_d  = cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_d = DONE;
                        ready_d = 1'b1;
                        quot_d  = neg_quot_q ? (~q_next + WIDTH'(1)) : q_next;
                        rem_d   = neg_rem_q ? (~r_next + WIDTH'(1)) : r_next;
                    end
                end
            end
            DZERO: begin
                if (annul_i) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                    ready_d = 1'b1;
                    quot_d  = '1;
                    rem_d   = opa_q;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Low in DONE so EX advances on that edge; annul drops it in the same cycle.
    assign stall_div = ((state_q == IDLE) && start_i && !annul_i) ||
                       (((state_q == BUSY) || (state_q == DZERO)) && !annul_i);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            dvd_q      <= '0;
            dvs_q      <= '0;
            part_q     <= '0;
            opa_q      <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            ready_q    <= 1'b0;
            quot_q     <= '0;
            rem_q      <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dvd_q      <= dvd_d;
            dvs_q      <= dvs_d;
            part_q     <= part_d;
            opa_q      <= opa_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            ready_q    <= ready_d;
            quot_q     <= quot_d;
            rem_q      <= rem_d;
        end
    end

    assign ready_o = ready_q;
    assign quot_o  = quot_q;
    assign rem_o   = rem_q;
endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer: driver tasks issue divides, a monitor
// pops expected {quot,rem} pairs from a queue whenever ready_o pulses.
module tb_div_sequencer;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start_i, signed_i, annul_i;
    logic [W-1:0] opa_i, opb_i;
    logic         stall_div, ready_o;
    logic [W-1:0] quot_o, rem_o;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic [2*W-1:0] exp_q[$];

    div_sequencer #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .signed_i(signed_i),
        .annul_i(annul_i), .opa_i(opa_i), .opb_i(opb_i),
        .stall_div(stall_div), .ready_o(ready_o), .quot_o(quot_o), .rem_o(rem_o)
    );

    // clock / reset block
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // scoreboard monitor
    initial begin
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && ready_o === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_ready", {{(2*W-1){1'b0}}, ready_o}, '0);
                end else begin
                    check("result", {quot_o, rem_o}, exp_q.pop_front());
                end
            end
        end
    end

    // driver tasks
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn);
        @(negedge clk);
        opa_i    = a;
        opb_i    = b;
        signed_i = sgn;
        start_i  = 1'b1;
        #1;
    endtask

    task automatic wait_stall(output int n);
        n = 0;
        while (stall_div === 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("stall_timeout", 64'(n), 64'(0));
    endtask

    task automatic run(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic sgn, input logic [W-1:0] q, input logic [W-1:0] r,
                       input int exp_stall);
        int n;
        exp_q.push_back({q, r});
        issue(a, b, sgn);
        wait_stall(n);
        check({name, "_stall_cycles"}, 64'(n), 64'(exp_stall));
        check({name, "_ready"}, 64'(ready_o), 64'(1));
        start_i = 1'b0;
        @(negedge clk);
        check({name, "_ready_pulse"}, 64'(ready_o), 64'(0));
        check({name, "_idle_stall"}, 64'(stall_div), 64'(0));
    endtask

    initial begin
        int n, t1, t2;
        rst = 1'b1; start_i = 1'b0; signed_i = 1'b0; annul_i = 1'b0;
        opa_i = '0; opb_i = '0;
        repeat (2) @(negedge clk);
        check("rst_ready", 64'(ready_o), 64'(0));
        check("rst_quot", 64'(quot_o), 64'(0));
        check("rst_rem", 64'(rem_o), 64'(0));
        check("rst_stall", 64'(stall_div), 64'(0));
        rst = 1'b0;

        run("divu_100_7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 33);
        // -7/2 truncates toward zero: q=-3, r=-1
        run("div_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33);
        run("div_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 33);
        run("div_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 33);
        run("div_m8_m3", 32'hFFFF_FFF8, 32'hFFFF_FFFD, 1'b1, 32'd2, 32'hFFFF_FFFE, 33);
        run("divu_max_16", 32'hFFFF_FFFF, 32'h10, 1'b0, 32'h0FFF_FFFF, 32'hF, 33);
        run("divu_wide", 32'hFFFF_FFFF, 32'h8000_0001, 1'b0, 32'd1, 32'h7FFF_FFFE, 33);
        run("divu_5_0", 32'd5, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd5, 2);

        // start and annul together in IDLE: never accepted
        @(negedge clk);
        opa_i = 32'd50; opb_i = 32'd5; signed_i = 1'b0;
        start_i = 1'b1; annul_i = 1'b1;
        #1 check("idle_annul_stall", 64'(stall_div), 64'(0));
        @(negedge clk);
        check("idle_annul_stall2", 64'(stall_div), 64'(0));
        start_i = 1'b0; annul_i = 1'b0;
        repeat (3) @(negedge clk);

        // annul at BUSY cycle 10
        issue(32'd100, 32'd7, 1'b0);
        repeat (10) @(negedge clk);
        check("busy_stall_pre_annul", 64'(stall_div), 64'(1));
        annul_i = 1'b1;
        #1 check("annul_stall_drop", 64'(stall_div), 64'(0));
        @(negedge clk);
        annul_i = 1'b0; start_i = 1'b0;
        #1 check("annul_back_idle", 64'(stall_div), 64'(0));
        repeat (40) @(negedge clk);
        check("annul_keeps_quot", 64'(quot_o), 64'(32'hFFFF_FFFF));
        check("annul_keeps_rem", 64'(rem_o), 64'(32'd5));
        run("divu_9_3", 32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 33);

        // back-to-back with start held
        exp_q.push_back({32'd3, 32'd2});
        exp_q.push_back({32'd1, 32'd0});
        issue(32'd20, 32'd6, 1'b0);
        wait_stall(n);
        check("b2b_first_stall", 64'(n), 64'(33));
        t1 = cyc;
        opa_i = 32'd7; opb_i = 32'd7;
        @(negedge clk);
        check("b2b_accept_stall", 64'(stall_div), 64'(1));
        wait_stall(n);
        t2 = cyc;
        check("b2b_second_stall", 64'(n), 64'(33));
        check("b2b_pulse_gap", 64'(t2 - t1), 64'(34));
        start_i = 1'b0;
        @(negedge clk);

        // reset at BUSY cycle 15
        issue(32'd20, 32'd6, 1'b0);
        repeat (15) @(negedge clk);
        start_i = 1'b0;
        rst = 1'b1;
        #1;
        check("midrst_quot", 64'(quot_o), 64'(0));
        check("midrst_rem", 64'(rem_o), 64'(0));
        check("midrst_ready", 64'(ready_o), 64'(0));
        check("midrst_stall", 64'(stall_div), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        #1 check("post_rst_stall", 64'(stall_div), 64'(0));
        repeat (40) @(negedge clk);
        check("post_rst_quot", 64'(quot_o), 64'(0));
        run("divu_20_6_after_rst", 32'd20, 32'd6, 1'b0, 32'd3, 32'd2, 33);

        repeat (3) @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
